// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear stopwatch with 1 Hz prescaler, BCD seconds and digit scan
module stopwatch_ctrl #(
    parameter int FRQ       = 50_000_000,
    parameter int SCAN_BITS = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lc,
    output logic       tick,
    output logic       running,
    output logic [1:0] state,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] ssd_sel,
    output logic [3:0] digit
);

    localparam int QW = $clog2(FRQ);
    localparam logic [QW-1:0] Q_MAX = QW'(FRQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_ss_s1, r_ss_s2, r_ss_prev;
    logic                   r_lc_s1, r_lc_s2, r_lc_prev;
    logic [QW-1:0]          r_q;
    logic                   r_tick;
    logic [3:0]             r_tens, r_ones;
    logic [3:0]             r_lap_tens, r_lap_ones;
    logic [SCAN_BITS-1:0]   r_scan;

    logic                   w_ss_ev, w_lc_ev;
    logic                   w_latch, w_clear;
    logic                   w_run, w_wrap;
    logic [3:0]             w_tens_nx, w_ones_nx;

    // Start/stop has priority: a simultaneous lap/clear press is discarded.
    assign w_ss_ev = r_ss_s2 & ~r_ss_prev;
    assign w_lc_ev = r_lc_s2 & ~r_lc_prev & ~w_ss_ev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ss_s1   <= 1'b0;
            r_ss_s2   <= 1'b0;
            r_ss_prev <= 1'b0;
            r_lc_s1   <= 1'b0;
            r_lc_s2   <= 1'b0;
            r_lc_prev <= 1'b0;
        end else begin
            r_ss_s1   <= btn_ss;
            r_ss_s2   <= r_ss_s1;
            r_ss_prev <= r_ss_s2;
            r_lc_s1   <= btn_lc;
            r_lc_s2   <= r_lc_s1;
            r_lc_prev <= r_lc_s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_ev) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_ss_ev) begin
                    w_next = S_PAUSE;
                end else if (w_lc_ev) begin
                    w_next  = S_LAP;
                    w_latch = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ss_ev)      w_next = S_PAUSE;
                else if (w_lc_ev) w_next = S_RUN;
            end
            S_PAUSE: begin
                if (w_ss_ev) begin
                    w_next = S_RUN;
                end else if (w_lc_ev) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Wrap is judged on the pre-edge state, so a same-edge state change never gains or loses a second.
    assign w_run  = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_wrap = w_run && (r_q == Q_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (w_clear || r_state == S_IDLE) begin
                r_q <= '0;
            end else if (w_wrap) begin
                r_q <= '0;
            end else if (w_run) begin
                r_q <= r_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_tens_nx = r_tens;
        w_ones_nx = r_ones + 4'd1;
        if (r_ones >= 4'd9) begin
            w_ones_nx = 4'd0;
            w_tens_nx = (r_tens >= 4'd5) ? 4'd0 : r_tens + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (w_clear) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (w_wrap) begin
            r_tens <= w_tens_nx;
            r_ones <= w_ones_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lap_tens <= 4'd0;
            r_lap_ones <= 4'd0;
        end else if (w_latch) begin
            r_lap_tens <= r_tens;
            r_lap_ones <= r_ones;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    assign tick     = r_tick;
    assign running  = w_run;
    assign state    = r_state;
    assign sec_tens = (r_state == S_LAP) ? r_lap_tens : r_tens;
    assign sec_ones = (r_state == S_LAP) ? r_lap_ones : r_ones;
    assign ssd_sel  = r_scan[SCAN_BITS-1 -: 2];

    always_comb begin
        digit = 4'hF;
        case (ssd_sel)
            2'd0:    digit = sec_ones;
            2'd1:    digit = sec_tens;
            default: digit = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - randomized and directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    localparam int FRQ = 4;
    localparam int SB  = 4;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lc = 1'b0;
    logic       tick, running;
    logic [1:0] state, ssd_sel;
    logic [3:0] sec_tens, sec_ones, digit;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_ctrl #(.FRQ(FRQ), .SCAN_BITS(SB)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_ss   (btn_ss),
        .btn_lc   (btn_lc),
        .tick     (tick),
        .running  (running),
        .state    (state),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .ssd_sel  (ssd_sel),
        .digit    (digit)
    );

    always #5 clk = ~clk;

    // Reference: whole seconds as an integer, prescaler phase as an integer, button history per edge.
    int       m_st, m_q, m_secs, m_lap, m_scan;
    bit       m_tick;
    bit [2:0] h_ss, h_lc;
    bit       e_ss, e_lc, e_run, e_wrap;
    int       n_st, n_q, n_secs;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_q = 0; m_secs = 0; m_lap = 0; m_scan = 0; m_tick = 0;
            h_ss = 3'b000; h_lc = 3'b000;
        end else begin
            e_ss   = h_ss[1] & ~h_ss[2];
            e_lc   = h_lc[1] & ~h_lc[2] & ~e_ss;
            e_run  = (m_st == 1) || (m_st == 3);
            e_wrap = e_run && (m_q == FRQ - 1);
            m_tick = e_wrap;
            n_q    = (m_st == 0 || e_wrap) ? 0 : (e_run ? m_q + 1 : m_q);
            n_secs = e_wrap ? (m_secs + 1) % 60 : m_secs;
            n_st   = m_st;
            case (m_st)
                0: if (e_ss) n_st = 1;
                1: if (e_ss) n_st = 2; else if (e_lc) begin n_st = 3; m_lap = m_secs; end
                3: if (e_ss) n_st = 2; else if (e_lc) n_st = 1;
                default: if (e_ss) n_st = 1; else if (e_lc) begin n_st = 0; n_q = 0; n_secs = 0; end
            endcase
            m_st   = n_st;
            m_q    = n_q;
            m_secs = n_secs;
            m_scan = (m_scan + 1) % (1 << SB);
            h_ss   = {h_ss[1:0], btn_ss};
            h_lc   = {h_lc[1:0], btn_lc};
        end
    end

    function automatic logic [17:0] model_out();
        int disp, sel, dg;
        disp = (m_st == 3) ? m_lap : m_secs;
        sel  = m_scan >> (SB - 2);
        dg   = (sel == 0) ? disp % 10 : (sel == 1) ? disp / 10 : 15;
        return {m_tick, (m_st == 1 || m_st == 3), 2'(m_st), 4'(disp / 10), 4'(disp % 10), 2'(sel), 4'(dg)};
    endfunction

    wire [17:0] dut_out = {tick, running, state, sec_tens, sec_ones, ssd_sel, digit};

    always @(negedge clk) begin
        n_tests++;
        if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t: got %h, expected %h", $time, dut_out, model_out());
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int n, ticks, guard;

    initial begin
        #12;
        check("reset_outputs", int'(dut_out), 0);
        #10 reset = 1'b1;
        wait_cyc(2);

        // Start: state changes at the third edge after the press.
        btn_ss = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (state != 2'd1 && n < 20);
        check("ss_latency", n, 3);
        n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < 20);
        check("first_tick", n, FRQ);
        btn_ss = 1'b0;

        ticks = 1; guard = 0;
        while (ticks < 60 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (tick) begin
                ticks++;
                if (ticks == 59) check("disp_59", sec_tens * 10 + sec_ones, 59);
            end
        end
        check("ticks_60", ticks, 60);
        check("wrap_00", sec_tens * 10 + sec_ones, 0);

        // Holding start/stop for 100 cycles pauses exactly once.
        btn_ss = 1'b1; wait_cyc(100);
        check("hold_single", state, 2);
        btn_ss = 1'b0; wait_cyc(3);
        btn_ss = 1'b1; wait_cyc(5); btn_ss = 1'b0; wait_cyc(2);
        check("resume_run", state, 1);

        btn_ss = 1'b1; btn_lc = 1'b1; wait_cyc(5);
        check("both_ss_wins", state, 2);
        btn_ss = 1'b0; btn_lc = 1'b0; wait_cyc(3);

        btn_lc = 1'b1; wait_cyc(5); btn_lc = 1'b0; wait_cyc(2);
        check("clear_idle", state, 0);
        check("clear_disp", sec_tens * 10 + sec_ones, 0);
        btn_lc = 1'b1; wait_cyc(5); btn_lc = 1'b0; wait_cyc(6);
        check("lc_idle_ignored", state, 0);
        check("idle_no_count", sec_tens * 10 + sec_ones, 0);

        // Lap then asynchronous reset between edges.
        btn_ss = 1'b1; wait_cyc(5); btn_ss = 1'b0; wait_cyc(30);
        btn_lc = 1'b1; wait_cyc(5); btn_lc = 1'b0; wait_cyc(2);
        check("lap_state", state, 3);
        wait_cyc(25);
        check("lap_still_running", running, 1);
        @(posedge clk); #2 reset = 1'b0; #1;
        check("async_reset", int'(dut_out), 0);
        #4 reset = 1'b1;
        wait_cyc(4);
        check("post_reset_idle", state, 0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 9) == 0)  btn_lc = ~btn_lc;
            if ($urandom_range(0, 1499) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end

        wait_cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
